// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine: op codes,
// FSM state encodings, iteration count and small op-decode helpers.
package muldiv_pkg;

    // Operation codes shared with the decoder; any other code is not mult/div.
    localparam logic [2:0] OP_MULT  = 3'd4;
    localparam logic [2:0] OP_MULTU = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_DIVU  = 3'd7;

    // Number of shift iterations per operation (one operand bit per cycle).
    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_SIGN = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide engine. Operands are reduced to
// magnitudes at acceptance, a shared 64-bit accumulator runs 32 shift-add or
// restoring shift-subtract steps, then a sign stage fixes up the result.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        b_zero_q, b_zero_d;
    logic [32:0] mag_a_q, mag_a_d;
    logic [32:0] mag_b_q, mag_b_d;
    logic [63:0] acc_q, acc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        in_signed;
    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] prod_neg;
    logic [31:0] quo_fix, rem_fix;

    // Operand magnitudes and one step of each iterative datapath.
    always_comb begin
        in_signed = is_signed_op(op);
        a_abs     = (in_signed && a[31]) ? (32'd0 - a) : a;
        b_abs     = (in_signed && b[31]) ? (32'd0 - b) : b;
        accept    = start && is_md_op(op) && ((state_q == MD_IDLE) || (state_q == MD_DONE));

        // Shift-add: conditionally add multiplicand to the upper half, then shift right.
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? mag_a_q : 33'd0);
        // Restoring divide: partial remainder shifted left with next dividend bit.
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_shift >= mag_b_q);
        // The true difference is below the divisor, so 32 bits hold it exactly.
        div_diff  = div_shift[31:0] - mag_b_q[31:0];

        prod_neg  = 64'd0 - acc_q;
        quo_fix   = (sign_a_q ^ sign_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix   = sign_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    // Next-state logic for the control FSM and the shared accumulator.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (flush) begin
            // Abort without touching the held result.
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_CALC: begin
                    cnt_d = cnt_q + 5'd1;
                    if (is_div_q) begin
                        acc_d = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                    if (cnt_q == 5'(MD_ITER - 1)) begin
                        state_d = MD_SIGN;
                    end
                end
                MD_SIGN: begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = b_zero_q ? 32'hFFFF_FFFF : quo_fix;
                    end else if (sign_a_q ^ sign_b_q) begin
                        {hi_d, lo_d} = prod_neg;
                    end else begin
                        {hi_d, lo_d} = acc_q;
                    end
                    state_d = MD_DONE;
                end
                default: begin
                    // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
                    if (accept) begin
                        state_d  = MD_CALC;
                        cnt_d    = 5'd0;
                        is_div_d = is_div_op(op);
                        sign_a_d = in_signed && a[31];
                        sign_b_d = in_signed && b[31];
                        b_zero_d = (b == 32'd0);
                        mag_a_d  = {1'b0, a_abs};
                        mag_b_d  = {1'b0, b_abs};
                        acc_d    = is_div_op(op) ? {32'd0, a_abs} : {32'd0, b_abs};
                    end else begin
                        state_d = MD_IDLE;
                    end
                end
            endcase
        end

        busy_d = (state_d == MD_CALC) || (state_d == MD_SIGN);
        done_d = (state_d == MD_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            mag_a_q  <= 33'd0;
            mag_b_q  <= 33'd0;
            acc_q    <= 64'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed requests push expected results,
// a monitor pops and checks on every done pulse (value and latency).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          e0;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cyc_last = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", nm, act);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            done_cyc_last = cyc;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, {32'd0, hi_out}, {32'd0, e.hi});
                check({e.name, "_lo"}, {32'd0, lo_out}, {32'd0, e.lo});
                check({e.name, "_latency"}, 64'(cyc - e.e0), 64'd33);
            end
        end
    end

    // Called at a negedge; request is sampled on the next posedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        e.hi   = eh;
        e.lo   = el;
        e.e0   = cyc;
        e.name = nm;
        sb.push_back(e);
        start = 1'b0;
        op    = 3'd0;
    endtask

    // Wait for a done pulse (bounded), counting busy cycles on the way.
    task automatic wait_done(input string nm, output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) return;
        end
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s_timeout: got no done within 100 cycles expected done", nm);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got simulation stuck expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        int idle_busy;
        int d1;

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hi", {32'd0, hi_out}, 64'd0);
        check("reset_lo", {32'd0, lo_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // MULT -2 * 3
        @(negedge clk);
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg2x3");
        wait_done("mult_neg2x3", bc);
        check("mult_busy_cycles", 64'(bc), 64'd33);

        // MULTU max * max
        @(negedge clk);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        wait_done("multu_max", bc);

        // DIV -7 / 2 -> q=-3, r=-1
        @(negedge clk);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
        wait_done("div_neg7_2", bc);

        // DIVU 7 / 0 -> hi=a, lo=all ones
        @(negedge clk);
        issue(OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_by0");
        wait_done("divu_by0", bc);
        check("divu_by0_busy_cycles", 64'(bc), 64'd33);

        // DIV most-negative / -1, then back-to-back MULTU in the done cycle
        @(negedge clk);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
        wait_done("div_ovf", bc);
        d1 = cyc;
        issue(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, "b2b_multu");
        check("b2b_busy_after_accept", {63'd0, busy}, 64'd1);
        wait_done("b2b_multu", bc);
        check("b2b_done_spacing", 64'(cyc - d1), 64'd34);

        // Flush at cycle 10 of a DIVU, with a simultaneous start that must be ignored
        @(negedge clk);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd3;
        @(posedge clk);
        #1;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_done", {63'd0, done}, 64'd0);
        check("flush_hi_hold", {32'd0, hi_out}, 64'd0);
        check("flush_lo_hold", {32'd0, lo_out}, 64'd30);
        flush = 1'b0;
        start = 1'b0;
        idle_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) idle_busy++;
        end
        check("flush_start_ignored", 64'(idle_busy), 64'd0);

        // Reset at cycle 20 of a MULT
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'h0000_1234;
        b     = 32'h0000_5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midop_rst_busy", {63'd0, busy}, 64'd0);
        check("midop_rst_done", {63'd0, done}, 64'd0);
        check("midop_rst_hi", {32'd0, hi_out}, 64'd0);
        check("midop_rst_lo", {32'd0, lo_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // start with a non-mult/div op
        @(negedge clk);
        start = 1'b1;
        op    = 3'd1;
        a     = 32'd5;
        b     = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        idle_busy = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) idle_busy++;
        end
        check("bad_op_busy_cycles", 64'(idle_busy), 64'd0);

        // DIVU 100 / 7 -> q=14, r=2
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
        wait_done("divu_100_7", bc);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide engine in the EX stage, feeding the HI/LO register pair. It accepts MULT, MULTU, DIV and DIVU requests with a start/busy/done handshake. It computes over 32 iteration cycles and presents a 64-bit {hi, lo} result with a one-cycle done pulse, which the HI/LO block captures as its write enable. The pipeline controller holds any HI/LO read (MFHI/MFLO) and any new mult/div instruction while busy is high.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe, sampled on the clock edge.
- op  in  3  operation code using the shared `MULT/`MULTU/`DIV/`DIVU encodings; other codes are not mult/div.
- a  in  32  rs operand (multiplicand / dividend).
- b  in  32  rt operand (multiplier / divisor).
- flush  in  1  synchronous abort from exception/branch-kill logic.
- busy  out  1  operation in progress; the stall source for the pipeline.
- done  out  1  one-cycle pulse; hi_out/lo_out are valid in that cycle.
- hi_out  out  32  product[63:32] or remainder.
- lo_out  out  32  product[31:0] or quotient.

## Operation
- States:
  - IDLE: waits for a request.
  - CALC: runs 32 iterations, with a 5-bit counter.
  - SIGN: applies sign correction and registers the result.
  - DONE: asserts done, then returns to IDLE.
- Request acceptance:
  - A request is accepted in IDLE or DONE when start=1 and op is one of the four mult/div codes.
  - On acceptance, the block latches op, the operand signs (for the signed ops) and 33-bit magnitudes |a| and |b|.
  - For the unsigned ops the magnitudes are the raw operands, zero-extended.
- start with any other op: ignored, state unchanged.
- start in CALC or SIGN: ignored. The requester must not issue while busy is high.
- Multiply: radix-2 shift-add on the magnitudes, one multiplier bit per cycle, into a 64-bit accumulator.
- Divide: restoring shift-subtract on the magnitudes, one quotient bit per cycle. Remainder is 33 bits wide internally.
- SIGN state rules:
  - Signed product is negated when sign(a)^sign(b) = 1.
  - Signed quotient is negated when sign(a)^sign(b) = 1.
  - Signed remainder takes the sign of a.
  - All results are truncated to 32/64 bits.
- Divide by zero (b=0), all divide ops: hi_out=a, lo_out=32'hFFFFFFFF. Full latency still applies; no exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: lo_out=0x80000000, hi_out=0. This falls out of the 33-bit magnitude path.
- Output hold: hi_out/lo_out hold their last result until the next SIGN state. They are not cleared by flush.
- flush=1:
  - Forces IDLE on the next edge from any state, with no done pulse.
  - flush has priority over start in the same cycle.
- rst=1: next edge forces IDLE and clears busy=0, done=0, hi_out=0, lo_out=0. This applies even mid-operation.

## Timing
- Call the accepting edge E0.
- Cycle numbering: cycle k is the cycle after edge Ek.
- Busy and done:
  - busy=1 in cycles 0–32: CALC in cycles 0–31, SIGN in cycle 32.
  - done=1 in cycle 33 only (state DONE). busy=0 in cycle 33.
  - Fixed latency is 34 edges from start to the done cycle, independent of operand values.
- HI/LO capture: hi_out/lo_out update at edge E33 and are stable while done=1. HI/LO samples them at edge E34.
- Back-to-back: start=1 during the done cycle is accepted at E34. busy rises in the following cycle, with no idle gap.
- busy is registered, with no combinational path from start to busy. done is registered.
- flush and rst both take effect at the sampling edge. The cycle after that edge shows busy=0, done=0.

## Structure
- The shared header defines the op macros (`MULT, `MULTU, `DIV, `DIVU), which this block reuses unchanged.
- Add to the shared header: the 2-bit state encodings (MD_IDLE, MD_CALC, MD_SIGN, MD_DONE) and MD_ITER=32.
- No sub-module: the control FSM and the shared 64-bit shift datapath stay in one module. Multiply and divide share the accumulator register.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 -> done in cycle 33 after the accepting edge, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA; busy high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi_out=0xFFFFFFFE, lo_out=0x00000001.
- DIV a=-7, b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). DIVU a=7, b=0 -> hi_out=7, lo_out=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0. Then a back-to-back MULTU 5×6 started in the done cycle -> next done exactly 34 edges later, lo_out=30.
- Flush at cycle 10 of a DIVU -> idle next cycle, no done pulse, hi_out/lo_out keep prior values. A start in the same cycle as flush is ignored.
- rst asserted at cycle 20 of a MULT -> next cycle busy=0, done=0, hi_out=lo_out=0. start with a non-mult/div op -> busy stays 0.
